// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// state encoding, word geometry and a small state-classification helper.
package loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_SHIFT     = 2;

    // States in which the loader is willing to take a stream byte.
    function automatic logic is_rx_state(input state_t s);
        logic rx;
        case (s)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: rx = 1'b1;
            default:                           rx = 1'b0;
        endcase
        return rx;
    endfunction

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Little-endian byte-to-word assembler. o_word already includes the byte being
// loaded, so the caller can capture the finished word on the same edge as o_word_full.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  i_byte,
    input  logic        i_load,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [23:0] r_word;
    logic [1:0]  r_idx;

    // Shift register and byte index; the index wraps after the fourth byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_word <= 24'h000000;
            r_idx  <= 2'd0;
        end else if (i_load) begin
            r_word <= {i_byte, r_word[23:8]};
            r_idx  <= r_idx + 2'd1;
        end
    end

    assign o_word      = {i_byte, r_word};
    assign o_word_full = i_load && (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: framed byte stream -> instruction memory writes, holding the core in
// reset until the image is in. Define LOADER_CHECKSUM_EN to add the trailing XOR check.
module inst_mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned        MAX_WORDS = 256,
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       word_count
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CHK;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t            r_state, w_state_next;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [15:0]       r_word_count;
    logic              r_rx_ready, r_mem_we, r_cpu_reset, r_load_done, r_load_error;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              w_xfer, w_asm_load, w_word_full, w_last;
    logic [15:0]       w_len;
    logic [31:0]       w_word;

    assign w_xfer     = rx_valid && r_rx_ready;
    assign w_len      = {rx_data, r_len_lo};
    assign w_asm_load = w_xfer && (r_state == S_DATA);
    assign w_last     = (r_word_count + 16'd1) == r_len;

    word_assembler u_asm (
        .clock       (clock),
        .reset       (reset),
        .i_byte      (rx_data),
        .i_load      (w_asm_load),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_chk;

    // Running XOR over the length bytes and every data byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chk <= 8'h00;
        end else if (w_xfer && (r_state == S_LEN_LO || r_state == S_LEN_HI || r_state == S_DATA)) begin
            r_chk <= r_chk ^ rx_data;
        end
    end
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_LEN_LO;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; unknown encodings fall into the error trap.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LEN_LO: begin
                if (w_xfer) w_state_next = S_LEN_HI;
                else        w_state_next = S_LEN_LO;
            end
            S_LEN_HI: begin
                if (!w_xfer)                         w_state_next = S_LEN_HI;
                else if (32'(w_len) > 32'(MAX_WORDS)) w_state_next = S_ERROR;
                else if (w_len == 16'd0)             w_state_next = S_AFTER_DATA;
                else                                 w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_word_full) w_state_next = S_WRITE;
                else             w_state_next = S_DATA;
            end
            S_WRITE: begin
                if (w_last) w_state_next = S_AFTER_DATA;
                else        w_state_next = S_DATA;
            end
            S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (!w_xfer)              w_state_next = S_CHK;
                else if (rx_data == r_chk) w_state_next = S_DONE;
                else                      w_state_next = S_ERROR;
`else
                w_state_next = S_ERROR;
`endif
            end
            S_DONE:  w_state_next = S_DONE;
            S_ERROR: w_state_next = S_ERROR;
            default: w_state_next = S_ERROR;
        endcase
    end

    // Length capture, word counter and memory write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len_lo     <= 8'h00;
            r_len        <= 16'h0000;
            r_word_count <= 16'h0000;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= BASE_ADDR;
            r_mem_wdata  <= 32'h00000000;
        end else begin
            if (w_xfer && r_state == S_LEN_LO) r_len_lo <= rx_data;
            if (w_xfer && r_state == S_LEN_HI) r_len <= w_len;
            if (r_state == S_WRITE) r_word_count <= r_word_count + 16'd1;
            r_mem_we <= (w_state_next == S_WRITE);
            if (w_word_full) begin
                r_mem_addr  <= BASE_ADDR + (ADDR_W'(r_word_count) << WORD_SHIFT);
                r_mem_wdata <= w_word;
            end
        end
    end

    // Status outputs lag the terminal state by one cycle; done/error are sticky.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_ready   <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_rx_ready   <= is_rx_state(w_state_next);
            r_cpu_reset  <= r_cpu_reset && (r_state != S_DONE);
            r_load_done  <= r_load_done || (r_state == S_DONE);
            r_load_error <= r_load_error || (r_state == S_ERROR);
        end
    end

    assign rx_ready   = r_rx_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader with a write scoreboard; follows LOADER_CHECKSUM_EN
// to append (and corrupt) the checksum byte.
module tb_inst_mem_loader;

    localparam logic [31:0] BASE = 32'h00000100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_we, cpu_reset, load_done, load_error;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  chk;

    inst_mem_loader #(.MAX_WORDS(256), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest pending expected write.
    always @(negedge clock) begin
        if (!reset && mem_we === 1'b1) begin
            check("ready_low_during_write", 32'(rx_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("write_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e[63:32]);
                check("write_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        rx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g;
        int t;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (g) begin
            @(negedge clock);
            rx_valid = 1'b0;
        end
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (rx_ready !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        end else begin
            @(posedge clock);
        end
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        while (frame_q.size() > 0) send_byte(frame_q.pop_front(), max_gap);
    endtask

    task automatic start_frame(input logic [15:0] n);
        frame_q = {};
        chk = n[7:0] ^ n[15:8];
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
    endtask

    task automatic add_word(input logic [31:0] w, input int idx);
        for (int i = 0; i < 4; i++) begin
            frame_q.push_back(w[8*i +: 8]);
            chk = chk ^ w[8*i +: 8];
        end
        exp_q.push_back({BASE + 32'(idx) * 32'd4, w});
    endtask

    task automatic end_frame(input logic [7:0] corrupt);
`ifdef LOADER_CHECKSUM_EN
        frame_q.push_back(chk ^ corrupt);
`else
        chk = chk ^ corrupt;
`endif
    endtask

    task automatic wait_end(input string tag, input logic exp_done, input logic exp_err,
                            input logic [15:0] exp_wc);
        int t;
        t = 0;
        while (load_done !== 1'b1 && load_error !== 1'b1 && t < 60) begin
            @(negedge clock);
            t++;
        end
        repeat (2) @(negedge clock);
        check({tag, "_done"}, 32'(load_done), 32'(exp_done));
        check({tag, "_error"}, 32'(load_error), 32'(exp_err));
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'(exp_wc));
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset values while reset is held.
        repeat (2) @(negedge clock);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;

        // Single word, good checksum (frame 01 00 93 00 50 00 [C2]).
        start_frame(16'd1);
        add_word(32'h00500093, 0);
        end_frame(8'h00);
        check("single_checksum_value", 32'(chk), 32'h000000C2);
        send_frame(0);
        wait_end("single", 1'b1, 1'b0, 16'd1);
        check("hold_addr", mem_addr, BASE);
        check("hold_wdata", mem_wdata, 32'h00500093);

`ifdef LOADER_CHECKSUM_EN
        // Same frame ending in C3: write happens, then error.
        do_reset();
        start_frame(16'd1);
        add_word(32'h00500093, 0);
        end_frame(8'h01);
        send_frame(0);
        wait_end("badchk", 1'b0, 1'b1, 16'd1);
`endif

        // Oversize length 257.
        do_reset();
        start_frame(16'd257);
        send_frame(0);
        wait_end("oversize", 1'b0, 1'b1, 16'd0);

        // Three words with random valid gaps.
        do_reset();
        start_frame(16'd3);
        add_word(32'hDEADBEEF, 0);
        add_word(32'h12345678, 1);
        add_word(32'hCAFEF00D, 2);
        end_frame(8'h00);
        send_frame(3);
        wait_end("three", 1'b1, 1'b0, 16'd3);

        // Zero-length image.
        do_reset();
        start_frame(16'd0);
        end_frame(8'h00);
        send_frame(0);
        wait_end("zero", 1'b1, 1'b0, 16'd0);

        // Reset after two data bytes of the first word, then a clean reload.
        do_reset();
        frame_q = {8'h02, 8'h00, 8'hAA, 8'hBB};
        send_frame(0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_word_count", 32'(word_count), 32'd0);
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_mem_addr", mem_addr, BASE);
        reset = 1'b0;
        start_frame(16'd2);
        add_word(32'h0000A0B7, 0);
        add_word(32'h00108093, 1);
        end_frame(8'h00);
        send_frame(1);
        wait_end("reload", 1'b1, 1'b0, 16'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Boot-time program loader sitting directly upstream of the single-cycle RV32 core and its instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory and holds the core in reset until the whole image has loaded and (optionally) passed a checksum.

Parameters:
- MAX_WORDS, 256, largest image accepted, in words.
- ADDR_W, 32, width of mem_addr.
- BASE_ADDR, 0, byte address of the first word written; must be word-aligned.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears the loader and asserts cpu_reset.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready at posedge.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  byte address of the word being written.
- mem_wdata  out  32  assembled instruction word.
- cpu_reset  out  1  holds the core in reset; high until load completes.
- load_done  out  1  image loaded successfully; sticky.
- load_error  out  1  length or checksum failure; sticky.
- word_count  out  16  number of words written so far.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes with byte 0 as word bits [7:0], then CHK (only when checksum is enabled).
- Reset values: rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_reset=1, load_done=0, load_error=0, word_count=0, state=S_LEN_LO.
- rx_ready is registered and equals 1 exactly in states S_LEN_LO, S_LEN_HI, S_DATA and S_CHK. It is 0 in the first cycle after reset deassertion.
- S_LEN_LO: on transfer, latch the low length byte -> S_LEN_HI.
- S_LEN_HI: on transfer, form N.
  - N > MAX_WORDS -> S_ERROR.
  - N == 0 -> S_CHK, or S_DONE when checksum is disabled.
  - Otherwise -> S_DATA.
- S_DATA: shift the byte into the assembler.
  - The byte index counts 0..3 and wraps to 0.
  - On the 4th byte -> S_WRITE. No byte is accepted in S_WRITE.
- S_WRITE: for exactly one cycle, mem_we=1, mem_wdata=assembled word, mem_addr=BASE_ADDR+4*word_count.
  - Next cycle word_count increments.
  - If the new word_count==N, go to S_CHK or S_DONE; otherwise return to S_DATA.
- mem_addr and mem_wdata hold their last value when mem_we=0.
- S_DONE: load_done=1 and cpu_reset=0, both registered (the core leaves reset on the cycle after entering S_DONE). rx_ready=0. Terminal until reset.
- S_ERROR: load_error=1, cpu_reset stays 1, rx_ready=0. Terminal until reset.
- Throughput: 4 accepted bytes plus 1 write cycle per word. rx_valid gaps stall the FSM with no state change.
- Reset mid-load: the FSM returns to S_LEN_LO and cpu_reset is re-asserted. Words already written remain in memory and are not cleared.
- word_count saturates only by design: N <= MAX_WORDS < 2^16.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR covers LEN_LO, LEN_HI and all data bytes.
  - After the data phase, S_CHK accepts one byte. Equal to the running XOR -> S_DONE, otherwise -> S_ERROR.
- Undefined:
  - No S_CHK state and no XOR register.
  - Completion of the last write (or N==0) goes straight to S_DONE. load_error arises only from N > MAX_WORDS.

Decomposition:
- Package loader_pkg holds:
  - the state encoding (S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERROR, 3 bits);
  - the constant BYTES_PER_WORD=4;
  - the constant WORD_SHIFT=2.
- One sub-module, word_assembler: a 4-byte little-endian shift register with a 2-bit index. Inputs are the byte and a load strobe; outputs are the 32-bit word and a word_full pulse.
- The FSM, counters and checksum stay in inst_mem_loader.

Test Plan:
- Single word, checksum on: bytes 01 00 93 00 50 00 C2 -> one mem_we pulse with addr 0x0 and wdata 0x00500093; load_done=1; cpu_reset falls one cycle after S_DONE.
- Bad checksum: same frame ending in C3 -> the write still occurs; load_error=1, cpu_reset stays 1, rx_ready=0 thereafter.
- Oversize: MAX_WORDS=256, length bytes 01 01 (N=257) -> S_ERROR immediately, no mem_we, load_error=1.
- Three words with random rx_valid gaps, BASE_ADDR=0x100 -> writes at 0x100, 0x104 and 0x108 with the correct words; word_count=3; no write while rx_valid is low.
- Zero length: 00 00 (+ checksum 00 when enabled) -> load_done with no writes and word_count=0.
- Reset asserted after 2 data bytes of word 1 -> cpu_reset=1, state S_LEN_LO, word_count=0; a following full frame loads correctly from BASE_ADDR.
